// File: rtl/handshake_arb_pkg.sv
// Shared sizing constants and types for the round-robin handshake arbiter.
package handshake_arb_pkg;

    localparam int N     = 3;
    localparam int WIDTH = 4;

    // Index width for an N-entry requester set; a single requester still
    // needs one bit so that every index vector has a legal width.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = idx_w(N);

    typedef logic [IDX_W-1:0] src_idx_t;

endpackage

// File: rtl/handshake_rr_arb_rr_pick.sv
// Combinational round-robin picker: the first set valid bit found by
// searching upward from ptr, wrapping modulo N.
module rr_pick #(
    parameter int N     = handshake_arb_pkg::N,
    parameter int IDX_W = handshake_arb_pkg::IDX_W
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand [N];
    logic [N-1:0]     hit;

    // Candidate gi is the requester sitting gi places above ptr; ptr is
    // always below N, so a single conditional subtract performs the wrap.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_off
            logic [IDX_W:0] sum;
            assign sum       = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign cand[gi]  = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                      : sum[IDX_W-1:0];
            assign hit[gi]   = valid[cand[gi]];
        end
    endgenerate

    // Lowest offset wins, so scan from the far end and let nearer hits overwrite.
    always_comb begin
        idx   = '0;
        any   = |hit;
        grant = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
            end
        end
        if (any) begin
            grant = N'(1) << idx;
        end
    end

endmodule

// File: rtl/handshake_rr_arb.sv
// N-to-1 round-robin arbiter with valid/ready handshakes on both sides and
// a single registered output beat that sustains one transfer per cycle.
module handshake_rr_arb #(
    parameter int N     = handshake_arb_pkg::N,
    parameter int WIDTH = handshake_arb_pkg::WIDTH
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic [N-1:0]                          handshake_arr_valid,
    output logic [N-1:0]                          handshake_arr_ready,
    input  logic [N-1:0][WIDTH-1:0]               in_data,
    output logic                                  handshake_valid,
    input  logic                                  handshake_ready,
    output logic [WIDTH-1:0]                      out_data,
    output logic [handshake_arb_pkg::idx_w(N)-1:0] out_src,
    output logic                                  idle
);

    localparam int IDX_W = handshake_arb_pkg::idx_w(N);

    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] ptr_next;
    logic [N-1:0]     pick_grant;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [IDX_W-1:0] out_src_reg;

    logic             can_load;
    logic             up_xfer;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid (handshake_arr_valid),
        .ptr   (ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // The output slot can accept a new beat if empty or draining this cycle.
    assign can_load = !out_valid_reg || handshake_ready;

    // Grant is masked during reset so no beat is accepted and then discarded.
    assign handshake_arr_ready = (can_load && pick_any && !RESET) ? pick_grant : '0;
    assign up_xfer             = |(handshake_arr_valid & handshake_arr_ready);

    // Next search start is just past the winner, wrapping from N-1 to 0.
    always_comb begin
        ptr_next = '0;
        if (pick_idx != IDX_W'(N - 1)) begin
            ptr_next = pick_idx + 1'b1;
        end
    end

    // Pointer advances only when a requester actually hands over a beat.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr_reg <= '0;
        end else if (up_xfer) begin
            ptr_reg <= ptr_next;
        end
    end

    // Output register: load on upstream transfer (replacing any draining
    // beat), otherwise empty on downstream transfer keeping payload/source.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_src_reg   <= '0;
        end else if (up_xfer) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= in_data[pick_idx];
            out_src_reg   <= pick_idx;
        end else if (handshake_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign handshake_valid = out_valid_reg;
    assign out_data        = out_data_reg;
    assign out_src         = out_src_reg;
    assign idle            = !out_valid_reg && !(|handshake_arr_valid);

endmodule

// File: tb/tb_handshake_rr_arb.sv
// Self-checking bench for handshake_rr_arb: directed scenarios followed by a
// randomized run against a queue-based reference model.
module tb_handshake_rr_arb;

    localparam int N     = handshake_arb_pkg::N;
    localparam int W     = handshake_arb_pkg::WIDTH;
    localparam int IDX_W = handshake_arb_pkg::IDX_W;

    logic                  CLK;
    logic                  RESET;
    logic [N-1:0]          valid;
    logic [N-1:0]          ready;
    logic [N-1:0][W-1:0]   in_data;
    logic                  hv;
    logic                  hr;
    logic [W-1:0]          out_data;
    handshake_arb_pkg::src_idx_t out_src;
    logic                  idle;

    int checks = 0;
    int errors = 0;

    handshake_rr_arb #(.N(N), .WIDTH(W)) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .handshake_arr_valid (valid),
        .handshake_arr_ready (ready),
        .in_data             (in_data),
        .handshake_valid     (hv),
        .handshake_ready     (hr),
        .out_data            (out_data),
        .out_src             (out_src),
        .idle                (idle)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic reset_dut();
        @(negedge CLK);
        RESET = 1'b1;
        valid = '0;
        hr    = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RESET = 1'b1; valid = '1; hr = 1'b1;
        #1;
        checks++; if (ready !== 3'b000) begin errors++; $display("FAIL rst_ready_during got=%b exp=000", ready); end
        @(negedge CLK);
        #1;
        checks++; if (ready !== 3'b000) begin errors++; $display("FAIL rst_ready_hold got=%b exp=000", ready); end
        checks++; if (hv !== 1'b0) begin errors++; $display("FAIL rst_hv got=%b exp=0", hv); end
        checks++; if (out_data !== '0 || out_src !== '0) begin errors++; $display("FAIL rst_out got=%h/%0d exp=0/0", out_data, out_src); end
        RESET = 1'b0; valid = '0;
        #1;
        checks++; if (ready !== 3'b000) begin errors++; $display("FAIL idle_ready got=%b exp=000", ready); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL idle_flag got=%b exp=1", idle); end
        $display("tx reset: ready=%b hv=%b idle=%b", ready, hv, idle);
    endtask

    task automatic test_round_robin();
        logic [W-1:0] exp_d [3];
        exp_d[0] = 4'hA; exp_d[1] = 4'hB; exp_d[2] = 4'hC;
        reset_dut();
        @(negedge CLK);
        valid = 3'b111; hr = 1'b1;
        in_data[0] = 4'hA; in_data[1] = 4'hB; in_data[2] = 4'hC;
        #1;
        checks++; if (ready !== 3'b001) begin errors++; $display("FAIL rr_first_grant got=%b exp=001", ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            #1;
            checks++;
            if (hv !== 1'b1 || out_src !== IDX_W'(i % 3) || out_data !== exp_d[i % 3]) begin
                errors++;
                $display("FAIL rr_beat%0d got=%b/%0d/%h exp=1/%0d/%h", i, hv, out_src, out_data, i % 3, exp_d[i % 3]);
            end
            $display("tx rr: beat %0d src=%0d data=%h", i, out_src, out_data);
        end
        valid = '0;
        @(negedge CLK);
    endtask

    task automatic test_stall();
        reset_dut();
        @(negedge CLK);
        valid = 3'b010; in_data[1] = 4'h5; hr = 1'b0;
        #1;
        checks++; if (ready !== 3'b010) begin errors++; $display("FAIL stall_grant got=%b exp=010", ready); end
        @(negedge CLK);
        in_data[1] = 4'h6;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (hv !== 1'b1 || out_data !== 4'h5 || out_src !== 2'd1 || ready !== 3'b000) begin
                errors++;
                $display("FAIL stall_hold%0d got=%b/%h/%0d/%b exp=1/5/1/000", c, hv, out_data, out_src, ready);
            end
            @(negedge CLK);
        end
        hr = 1'b1;
        #1;
        checks++; if (ready !== 3'b010) begin errors++; $display("FAIL stall_release_grant got=%b exp=010", ready); end
        @(negedge CLK);
        #1;
        checks++; if (hv !== 1'b1 || out_data !== 4'h6) begin errors++; $display("FAIL stall_second_beat got=%b/%h exp=1/6", hv, out_data); end
        valid = '0;
        @(negedge CLK);
        #1;
        checks++; if (hv !== 1'b0 || out_data !== 4'h6 || out_src !== 2'd1) begin errors++; $display("FAIL drain_hold got=%b/%h/%0d exp=0/6/1", hv, out_data, out_src); end
        $display("tx stall: drained data=%h src=%0d", out_data, out_src);
    endtask

    task automatic test_wrap();
        reset_dut();
        @(negedge CLK);
        valid = 3'b010; hr = 1'b1;
        #1;
        checks++; if (ready !== 3'b010) begin errors++; $display("FAIL wrap_g1 got=%b exp=010", ready); end
        @(negedge CLK);
        valid = 3'b101;
        #1;
        checks++; if (ready !== 3'b100) begin errors++; $display("FAIL wrap_g2 got=%b exp=100", ready); end
        @(negedge CLK);
        #1;
        checks++; if (out_src !== 2'd2) begin errors++; $display("FAIL wrap_src2 got=%0d exp=2", out_src); end
        checks++; if (ready !== 3'b001) begin errors++; $display("FAIL wrap_g0 got=%b exp=001", ready); end
        @(negedge CLK);
        #1;
        checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL wrap_src0 got=%0d exp=0", out_src); end
        checks++; if (ready !== 3'b100) begin errors++; $display("FAIL wrap_next got=%b exp=100", ready); end
        $display("tx wrap: src=%0d ready=%b", out_src, ready);
        valid = '0;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        reset_dut();
        @(negedge CLK);
        valid = 3'b111; hr = 1'b0;
        in_data[0] = 4'h1; in_data[1] = 4'h2; in_data[2] = 4'h3;
        @(negedge CLK);
        #1;
        checks++; if (hv !== 1'b1 || out_data !== 4'h1) begin errors++; $display("FAIL mid_held got=%b/%h exp=1/1", hv, out_data); end
        RESET = 1'b1; hr = 1'b1;
        #1;
        checks++; if (ready !== 3'b000) begin errors++; $display("FAIL mid_no_grant got=%b exp=000", ready); end
        @(negedge CLK);
        RESET = 1'b0; hr = 1'b0;
        #1;
        checks++; if (hv !== 1'b0 || out_src !== 2'd0 || out_data !== 4'h0) begin errors++; $display("FAIL mid_cleared got=%b/%0d/%h exp=0/0/0", hv, out_src, out_data); end
        checks++; if (ready !== 3'b001) begin errors++; $display("FAIL mid_first_grant got=%b exp=001", ready); end
        @(negedge CLK);
        #1;
        checks++; if (hv !== 1'b1 || out_src !== 2'd0) begin errors++; $display("FAIL mid_after got=%b/%0d exp=1/0", hv, out_src); end
        $display("tx reset_mid: src=%0d data=%h", out_src, out_data);
        valid = '0;
    endtask

    task automatic test_random();
        int           m_ptr;
        bit           m_hv;
        int           g;
        int           idx;
        logic [N-1:0] exp_ready;
        int           wait_cnt [N];
        int           src_q [$];
        logic [W-1:0] data_q [$];
        int           beats;
        beats = 0;
        m_ptr = 0;
        m_hv  = 1'b0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        reset_dut();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge CLK);
            valid = N'($urandom);
            for (int i = 0; i < N; i++) in_data[i] = W'($urandom);
            hr = ($urandom_range(0, 3) != 0);
            #1;
            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && valid[idx]) g = idx;
            end
            exp_ready = '0;
            if ((!m_hv || hr) && g >= 0) exp_ready[g] = 1'b1;
            checks++; if (ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, ready, exp_ready); end
            checks++; if (hv !== m_hv) begin errors++; $display("FAIL rnd_hv cyc=%0d got=%b exp=%b", cyc, hv, m_hv); end
            checks++; if (idle !== (!m_hv && valid == '0)) begin errors++; $display("FAIL rnd_idle cyc=%0d got=%b", cyc, idle); end
            // Downstream transfer: the presented beat must be the oldest queued one.
            if (m_hv && hr) begin
                checks++;
                if (src_q.size() == 0) begin
                    errors++; $display("FAIL rnd_sb_empty cyc=%0d", cyc);
                end else begin
                    if (out_src !== IDX_W'(src_q[0]) || out_data !== data_q[0]) begin
                        errors++;
                        $display("FAIL rnd_beat cyc=%0d got=%0d/%h exp=%0d/%h", cyc, out_src, out_data, src_q[0], data_q[0]);
                    end
                    void'(src_q.pop_front());
                    void'(data_q.pop_front());
                    beats++;
                end
            end
            // Track how many other grants each continuously-valid requester sits through.
            for (int i = 0; i < N; i++) if (!valid[i]) wait_cnt[i] = 0;
            if (exp_ready != '0) begin
                checks++;
                if (wait_cnt[g] > N - 1) begin errors++; $display("FAIL rnd_starve req=%0d waited=%0d max=%0d", g, wait_cnt[g], N - 1); end
                for (int i = 0; i < N; i++) if (i != g && valid[i]) wait_cnt[i]++;
                wait_cnt[g] = 0;
                src_q.push_back(g);
                data_q.push_back(in_data[g]);
                m_hv  = 1'b1;
                m_ptr = (g + 1) % N;
            end else if (hr) begin
                m_hv = 1'b0;
            end
        end
        checks++; if (src_q.size() != int'(m_hv)) begin errors++; $display("FAIL rnd_sb_left got=%0d exp=%0d", src_q.size(), int'(m_hv)); end
        $display("tx random: %0d beats delivered", beats);
        valid = '0;
    endtask

    initial begin
        RESET   = 1'b1;
        valid   = '0;
        hr      = 1'b0;
        in_data = '0;
        test_reset();
        test_round_robin();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
